// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  // Callers zero-extend narrower words; the padding does not change the XOR.
  function automatic logic uart_parity(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));

  // Wrapping on bit_end restarts the count for the following bit.
  always_ff @(posedge clk) begin
    if (reset || clear || bit_end) cnt <= '0;
    else                           cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pops one word per frame from the TX FIFO and serializes it.
module uart_tx_fifo_reader
  import uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  localparam int BW = $clog2(WIDTH + 1);

  uart_tx_state_t   state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic             par, par_n;
  logic             tx_n, busy_n, rd_n, done_n;
  logic             bit_end, timer_clear;

  // The baud count only runs while a bit is on the line.
  assign timer_clear = (state == IDLE) || (state == FETCH);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      par        <= 1'b0;
      tx         <= UART_IDLE_LEVEL;
      busy       <= 1'b0;
      fifo_rd_en <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      par        <= par_n;
      tx         <= tx_n;
      busy       <= busy_n;
      fifo_rd_en <= rd_n;
      tx_done    <= done_n;
    end
  end

  // tx is registered, so each branch loads the level of the bit that starts next.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    par_n     = par;
    tx_n      = tx;
    busy_n    = busy;
    rd_n      = 1'b0;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        tx_n   = UART_IDLE_LEVEL;
        busy_n = !fifo_empty;
        if (!fifo_empty) begin
          rd_n    = 1'b1;
          state_n = FETCH;
        end
      end
      FETCH: begin
        shreg_n   = fifo_data;
        par_n     = uart_parity(9'(fifo_data), PARITY_ODD != 0);
        bit_cnt_n = '0;
        tx_n      = UART_START_LEVEL;
        state_n   = START;
      end
      START: begin
        if (bit_end) begin
          tx_n    = shreg[0];
          shreg_n = shreg >> 1;
          state_n = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == BW'(WIDTH - 1)) begin
            bit_cnt_n = '0;
            if (PARITY_EN != 0) begin
              tx_n    = par;
              state_n = PARITY;
            end else begin
              tx_n    = UART_IDLE_LEVEL;
              state_n = STOP;
            end
          end else begin
            tx_n      = shreg[0];
            shreg_n   = shreg >> 1;
            bit_cnt_n = bit_cnt + BW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          tx_n    = UART_IDLE_LEVEL;
          state_n = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == BW'(STOP_BITS - 1)) begin
            bit_cnt_n = '0;
            busy_n    = 1'b0;
            done_n    = 1'b1;
            state_n   = IDLE;
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Directed bench: FIFO model plus expected-bit scoreboard for three parameter sets.
module tb_uart_tx_fifo_reader;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       fifo_empty0 = 1'b1, fifo_empty1 = 1'b1, fifo_empty2 = 1'b1;
  logic [7:0] fifo_data0 = 8'h00;
  logic [7:0] fifo_data_p = 8'hA5;
  logic       rd0, tx0, busy0, done0;
  logic       rd1, tx1, busy1, done1;
  logic       rd2, tx2, busy2, done2;

  uart_tx_fifo_reader #(.WIDTH(8), .CLKS_PER_BIT(CPB)) d0 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty0), .fifo_data(fifo_data0),
    .fifo_rd_en(rd0), .tx(tx0), .busy(busy0), .tx_done(done0));

  uart_tx_fifo_reader #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0),
                        .STOP_BITS(1)) d1 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty1), .fifo_data(fifo_data_p),
    .fifo_rd_en(rd1), .tx(tx1), .busy(busy1), .tx_done(done1));

  uart_tx_fifo_reader #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1),
                        .STOP_BITS(2)) d2 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty2), .fifo_data(fifo_data_p),
    .fifo_rd_en(rd2), .tx(tx2), .busy(busy2), .tx_done(done2));

  int         errors = 0;
  int         checks = 0;
  int         rd_cnt0 = 0, rd_cnt1 = 0, rd_cnt2 = 0;
  bit         junk = 1'b0;
  logic [7:0] fq[$];
  logic       exp_bits[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic upd();
    fifo_empty0 = (fq.size() == 0);
    if (junk)               fifo_data0 = 8'($urandom);
    else if (fq.size() > 0) fifo_data0 = fq[0];
    else                    fifo_data0 = 8'h00;
  endtask

  // One clock; the FIFO model pops on the edge where rd_en was high, flushes on reset.
  task automatic tick();
    logic p0, rst;
    logic [7:0] dummy;
    p0  = rd0;
    rst = reset;
    @(posedge clk);
    #1;
    if (rst) fq.delete();
    else if (p0 && fq.size() > 0) dummy = fq.pop_front();
    if (rd0) rd_cnt0++;
    if (rd1) rd_cnt1++;
    if (rd2) rd_cnt2++;
    upd();
  endtask

  task automatic fifo_push(input logic [7:0] b);
    fq.push_back(b);
    upd();
  endtask

  task automatic expect_frame(input logic [7:0] b, input int par_en, input int odd,
                              input int stops);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    if (par_en != 0) exp_bits.push_back((^b) ^ (odd != 0));
    for (int i = 0; i < stops; i++) exp_bits.push_back(1'b1);
  endtask

  function automatic logic txs(input int s);
    case (s)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic dones(input int s);
    case (s)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic busys(input int s);
    case (s)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  // Waits for the start edge, then checks every cycle of every bit against the scoreboard.
  task automatic rx_frame(input int sel, input int nbits, input bit jk, output int gap);
    int   w;
    logic b;
    w = 0;
    while (txs(sel) !== 1'b0 && w < 300) begin
      tick();
      w++;
    end
    gap = w;
    chk($sformatf("start_seen%0d", sel), txs(sel), 1'b0);
    if (w >= 300) return;
    chk($sformatf("busy_frame%0d", sel), busys(sel), 1'b1);
    if (jk) begin
      junk = 1'b1;
      upd();
    end
    for (int k = 0; k < nbits; k++) begin
      if (exp_bits.size() > 0) b = exp_bits.pop_front();
      else                     b = 1'bx;
      for (int j = 0; j < CPB; j++) begin
        chk($sformatf("d%0d_bit%0d_c%0d", sel, k, j), txs(sel), b);
        tick();
      end
    end
    junk = 1'b0;
    upd();
    chk($sformatf("tx_done%0d", sel), dones(sel), 1'b1);
    chk($sformatf("busy_end%0d", sel), busys(sel), 1'b0);
  endtask

  initial begin
    int gap;

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_tx", tx0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_rd", rd0, 1'b0);
    chk("rst_done", done0, 1'b0);

    // Empty FIFO: line stays idle, no pops.
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_tx", tx0, 1'b1);
      chk("idle_busy", busy0, 1'b0);
    end
    chk("idle_pops", rd_cnt0, 0);

    // Single 0xA5 frame, 8N1.
    rd_cnt0 = 0;
    fifo_push(8'hA5);
    expect_frame(8'hA5, 0, 0, 1);
    rx_frame(0, 10, 1'b0, gap);
    chk("pops_a5", rd_cnt0, 1);

    // Even parity, one stop bit.
    expect_frame(8'hA5, 1, 0, 1);
    fifo_empty1 = 1'b0;
    tick();
    fifo_empty1 = 1'b1;
    rx_frame(1, 11, 1'b0, gap);
    chk("pops_even", rd_cnt1, 1);

    // Odd parity, two stop bits.
    expect_frame(8'hA5, 1, 1, 2);
    fifo_empty2 = 1'b0;
    tick();
    fifo_empty2 = 1'b1;
    rx_frame(2, 12, 1'b0, gap);
    chk("pops_odd", rd_cnt2, 1);

    // Three queued bytes back to back.
    rd_cnt0 = 0;
    fifo_push(8'h01); expect_frame(8'h01, 0, 0, 1);
    fifo_push(8'h02); expect_frame(8'h02, 0, 0, 1);
    fifo_push(8'h03); expect_frame(8'h03, 0, 0, 1);
    rx_frame(0, 10, 1'b0, gap);
    rx_frame(0, 10, 1'b0, gap);
    chk("gap_1_2", gap, 2);
    rx_frame(0, 10, 1'b0, gap);
    chk("gap_2_3", gap, 2);
    chk("pops_three", rd_cnt0, 3);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("drained_tx", tx0, 1'b1);
      chk("drained_busy", busy0, 1'b0);
    end
    chk("pops_after_drain", rd_cnt0, 3);

    // Reset during data bit 3 of 0xFF.
    fifo_push(8'hFF);
    gap = 0;
    while (tx0 !== 1'b0 && gap < 300) begin
      tick();
      gap++;
    end
    chk("ff_start", tx0, 1'b0);
    for (int i = 0; i < CPB * 4 + 1; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_tx", tx0, 1'b1);
    chk("midrst_busy", busy0, 1'b0);
    chk("midrst_done", done0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("postrst_tx", tx0, 1'b1);
      chk("postrst_done", done0, 1'b0);
    end
    fifo_push(8'h3C);
    expect_frame(8'h3C, 0, 0, 1);
    rx_frame(0, 10, 1'b0, gap);

    // Junk on fifo_data after capture must not leak into the frame.
    fifo_push(8'h5A);
    expect_frame(8'h5A, 0, 0, 1);
    rx_frame(0, 10, 1'b1, gap);
    chk("sb_empty", exp_bits.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
